// File: rtl/lut_ram_wr_arbiter_if.sv
// lut_ram_wr_arbiter_if: requester handshakes, clear, and registered RAM write port.
interface lut_ram_wr_arbiter_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic                  clr;
   logic                  req0_valid;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req0_ready;
   logic                  req1_valid;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  req1_ready;
   logic                  ram_wr_en;
   logic [ADDR_WIDTH-1:0] ram_wr_addr;
   logic [DATA_WIDTH-1:0] ram_wr_data;
   logic                  init_busy;

   modport master (
      output clr, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready, ram_wr_en, ram_wr_addr, ram_wr_data, init_busy
   );

   modport slave (
      input  clr, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready, ram_wr_en, ram_wr_addr, ram_wr_data, init_busy
   );
endinterface

// File: rtl/lut_ram_wr_arbiter.sv
// lut_ram_wr_arbiter: round-robin arbiter for two writers onto one LUT RAM write port, with zero-fill.
module lut_ram_wr_arbiter #(
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int DATA_WIDTH = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   lut_ram_wr_arbiter_if.slave bus
);
   typedef enum logic {INIT, RUN} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  prio;
   logic                  rdy0, rdy1;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   always_ff @(posedge clk)
      state <= !rst_n ? INIT : state_nxt;

   always_comb begin
      state_nxt = state;
      rdy0      = 1'b0;
      rdy1      = 1'b0;
      if (state == INIT) begin
         state_nxt = (cnt == ADDR_WIDTH'(DEPTH - 1)) ? RUN : INIT;
      end else begin
         state_nxt = bus.clr ? INIT : RUN;
         rdy0      = !bus.clr && bus.req0_valid && (!bus.req1_valid || !prio);
         rdy1      = !bus.clr && bus.req1_valid && (!bus.req0_valid || prio);
      end
   end

   // cnt wraps to 0 on its own after DEPTH-1 because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         prio    <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (state == INIT) begin
         wr_en   <= 1'b1;
         wr_addr <= cnt;
         wr_data <= '0;
         cnt     <= cnt + ADDR_WIDTH'(1);
      end else begin
         wr_en <= rdy0 || rdy1;
         cnt   <= '0;
         if (rdy0) begin
            wr_addr <= bus.req0_addr;
            wr_data <= bus.req0_data;
            prio    <= 1'b1;
         end else if (rdy1) begin
            wr_addr <= bus.req1_addr;
            wr_data <= bus.req1_data;
            prio    <= 1'b0;
         end
      end
   end

   assign bus.req0_ready  = rdy0;
   assign bus.req1_ready  = rdy1;
   assign bus.ram_wr_en   = wr_en;
   assign bus.ram_wr_addr = wr_addr;
   assign bus.ram_wr_data = wr_data;
   assign bus.init_busy   = (state == INIT);
endmodule

// File: tb/tb_lut_ram_wr_arbiter.sv
// tb_lut_ram_wr_arbiter: directed vector table plus hand sequences for fill, clear and reset.
module tb_lut_ram_wr_arbiter;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DW    = 32;

   logic clk = 1'b0;
   logic rst_n;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] exp_mem [DEPTH];
   int checks = 0;
   int errors = 0;

   lut_ram_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   lut_ram_wr_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;

   typedef struct {
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          r0;
      logic          r1;
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.clr        = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic check_mem(input string name);
      for (int i = 0; i < DEPTH; i++) chk($sformatf("%s[%0d]", name, i), 64'(mem[i]), 64'(exp_mem[i]));
   endtask

   task automatic fill_check(input logic last_rdy);
      for (int a = 0; a < DEPTH; a++) begin
         step();
         chk($sformatf("fill_we%0d", a), 64'(bus.ram_wr_en), 64'(1));
         chk($sformatf("fill_addr%0d", a), 64'(bus.ram_wr_addr), 64'(a));
         chk($sformatf("fill_data%0d", a), 64'(bus.ram_wr_data), 64'(0));
         chk($sformatf("fill_busy%0d", a), 64'(bus.init_busy), 64'(a != DEPTH - 1));
         chk($sformatf("fill_rdy%0d", a), 64'(bus.req0_ready | bus.req1_ready),
             64'((a == DEPTH - 1) ? last_rdy : 1'b0));
      end
   endtask

   initial begin
      //        v0  a0    d0            v1  a1     d1         r0  r1  we  wa     wd
      vecs[0]  = '{1, 4'd5, 32'hDEADBEEF, 0, 4'd0,  32'h0,     1,  0,  1, 4'd5,  32'hDEADBEEF};
      vecs[1]  = '{0, 4'd0, 32'h0,        0, 4'd0,  32'h0,     0,  0,  0, 4'd5,  32'hDEADBEEF};
      vecs[2]  = '{0, 4'd0, 32'h0,        1, 4'd7,  32'h77,    0,  1,  1, 4'd7,  32'h77};
      vecs[3]  = '{1, 4'd1, 32'h101,      1, 4'd9,  32'h109,   1,  0,  1, 4'd1,  32'h101};
      vecs[4]  = '{1, 4'd2, 32'h102,      1, 4'd9,  32'h109,   0,  1,  1, 4'd9,  32'h109};
      vecs[5]  = '{1, 4'd2, 32'h102,      1, 4'd10, 32'h10A,   1,  0,  1, 4'd2,  32'h102};
      vecs[6]  = '{1, 4'd3, 32'h103,      1, 4'd10, 32'h10A,   0,  1,  1, 4'd10, 32'h10A};
      vecs[7]  = '{1, 4'd3, 32'h103,      1, 4'd11, 32'h10B,   1,  0,  1, 4'd3,  32'h103};
      vecs[8]  = '{1, 4'd4, 32'h104,      1, 4'd11, 32'h10B,   0,  1,  1, 4'd11, 32'h10B};
      vecs[9]  = '{1, 4'd4, 32'h104,      1, 4'd12, 32'h10C,   1,  0,  1, 4'd4,  32'h104};
      vecs[10] = '{0, 4'd0, 32'h0,        1, 4'd12, 32'h10C,   0,  1,  1, 4'd12, 32'h10C};
      vecs[11] = '{1, 4'd6, 32'h1,        0, 4'd0,  32'h0,     1,  0,  1, 4'd6,  32'h1};
      vecs[12] = '{0, 4'd0, 32'h0,        1, 4'd6,  32'h2,     0,  1,  1, 4'd6,  32'h2};

      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      rst_n          = 1'b0;
      bus.clr        = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_addr  = '0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b1;
      bus.req1_addr  = '0;
      bus.req1_data  = '0;
      step();
      step();
      chk("rst_we", 64'(bus.ram_wr_en), 64'(0));
      chk("rst_addr", 64'(bus.ram_wr_addr), 64'(0));
      chk("rst_data", 64'(bus.ram_wr_data), 64'(0));
      chk("rst_busy", 64'(bus.init_busy), 64'(1));
      chk("rst_rdy", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));

      idle();
      rst_n = 1'b1;
      #1;
      chk("c0_busy", 64'(bus.init_busy), 64'(1));
      fill_check(1'b0);
      step();
      chk("idle_we", 64'(bus.ram_wr_en), 64'(0));
      chk("idle_addr_hold", 64'(bus.ram_wr_addr), 64'(15));
      check_mem("fill0");

      foreach (vecs[i]) begin
         bus.req0_valid = vecs[i].v0;
         bus.req0_addr  = vecs[i].a0;
         bus.req0_data  = vecs[i].d0;
         bus.req1_valid = vecs[i].v1;
         bus.req1_addr  = vecs[i].a1;
         bus.req1_data  = vecs[i].d1;
         #1;
         chk($sformatf("v%0d_r0", i), 64'(bus.req0_ready), 64'(vecs[i].r0));
         chk($sformatf("v%0d_r1", i), 64'(bus.req1_ready), 64'(vecs[i].r1));
         step();
         chk($sformatf("v%0d_we", i), 64'(bus.ram_wr_en), 64'(vecs[i].we));
         chk($sformatf("v%0d_addr", i), 64'(bus.ram_wr_addr), 64'(vecs[i].wa));
         chk($sformatf("v%0d_data", i), 64'(bus.ram_wr_data), 64'(vecs[i].wd));
         if (vecs[i].we) exp_mem[vecs[i].wa] = vecs[i].wd;
      end
      idle();
      step();
      check_mem("table");

      // clear pulse with a pending req1: refused now, accepted first cycle of RUN
      bus.clr        = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req1_addr  = 4'd3;
      bus.req1_data  = 32'h55;
      #1;
      chk("clr_r1", 64'(bus.req1_ready), 64'(0));
      step();
      bus.clr = 1'b0;
      #1;
      chk("clr_we", 64'(bus.ram_wr_en), 64'(0));
      chk("clr_busy", 64'(bus.init_busy), 64'(1));
      chk("clr_r1_init", 64'(bus.req1_ready), 64'(0));
      fill_check(1'b1);
      step();
      idle();
      chk("clr_acc_we", 64'(bus.ram_wr_en), 64'(1));
      chk("clr_acc_addr", 64'(bus.ram_wr_addr), 64'(3));
      chk("clr_acc_data", 64'(bus.ram_wr_data), 64'(32'h55));
      step();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      exp_mem[3] = 32'h55;
      check_mem("clr");

      // reset in the accept cycle discards the write and refills
      bus.req0_valid = 1'b1;
      bus.req0_addr  = 4'd9;
      bus.req0_data  = 32'hBAD;
      rst_n          = 1'b0;
      #1;
      chk("rstacc_r0", 64'(bus.req0_ready), 64'(1));
      step();
      idle();
      rst_n = 1'b1;
      chk("rstacc_we", 64'(bus.ram_wr_en), 64'(0));
      chk("rstacc_addr", 64'(bus.ram_wr_addr), 64'(0));
      chk("rstacc_data", 64'(bus.ram_wr_data), 64'(0));
      chk("rstacc_busy", 64'(bus.init_busy), 64'(1));
      fill_check(1'b0);
      step();
      exp_mem[3] = '0;
      check_mem("rstacc");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
